// File: rtl/basemul_acc.sv
// Coefficient-wise mod-Q accumulator for K basemul output polynomials; after the
// K-th polynomial it streams the 256 reduced coefficients out over valid/ready.
module basemul_acc #(
  parameter int K = 3,
  parameter int Q = 3329
) (
  input  logic               clk,
  input  logic               set,
  input  logic               clr,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic signed [15:0] t1,
  input  logic signed [15:0] t0,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [11:0]        out_data,
  output logic [7:0]         out_idx,
  output logic               done
);

  typedef enum logic [1:0] {ACC, SETTLE, DRAIN} state_t;

  localparam logic signed [16:0] QS = 17'(Q);

  state_t      state, state_d;
  logic [6:0]  p;
  logic [1:0]  k;
  logic [11:0] mem [256];
  logic [11:0] lo_old, hi_old;
  logic [7:0]  nxt_idx;
  logic        hs, last_pair, last_out;

  function automatic logic [11:0] modadd(input logic [11:0] s, input logic signed [15:0] t);
    logic signed [16:0] sum;
    sum = $signed({5'b0, s}) + $signed({t[15], t});
    if (sum < 0)
      sum = sum + QS;
    else if (sum >= QS)
      sum = sum - QS;
    return sum[11:0];
  endfunction

  always_comb begin
    in_ready  = set && (state == ACC);
    hs        = in_valid && in_ready && !clr;
    last_pair = hs && (p == 7'd127) && (k == 2'(K - 1));
    last_out  = out_valid && out_ready && (out_idx == 8'd255);
    nxt_idx   = out_valid ? out_idx + 8'd1 : 8'd0;
    // First polynomial of a run overwrites, so stale buffer contents never leak in.
    lo_old    = (k == 2'd0) ? 12'd0 : mem[{p, 1'b0}];
    hi_old    = (k == 2'd0) ? 12'd0 : mem[{p, 1'b1}];
  end

  always_comb begin
    state_d = state;
    if (clr)
      state_d = ACC;
    else begin
      case (state)
        ACC:     if (last_pair) state_d = SETTLE;
        SETTLE:  state_d = DRAIN;
        DRAIN:   if (last_out) state_d = ACC;
        default: state_d = ACC;
      endcase
    end
  end

  always_ff @(posedge clk or negedge set) begin
    if (!set)
      state <= ACC;
    else
      state <= state_d;
  end

  always_ff @(posedge clk or negedge set) begin
    if (!set) begin
      p <= '0;
      k <= '0;
    end else if (clr) begin
      p <= '0;
      k <= '0;
    end else if (hs) begin
      p <= p + 7'd1;
      if (p == 7'd127)
        k <= (k == 2'(K - 1)) ? 2'd0 : k + 2'd1;
    end
  end

  // Pairs of one polynomial never share an address, so a same-cycle read-modify-write is hazard-free.
  always_ff @(posedge clk) begin
    if (hs) begin
      mem[{p, 1'b0}] <= modadd(lo_old, t0);
      mem[{p, 1'b1}] <= modadd(hi_old, t1);
    end
  end

  always_ff @(posedge clk or negedge set) begin
    if (!set) begin
      out_valid <= 1'b0;
      done      <= 1'b0;
      out_data  <= '0;
      out_idx   <= '0;
    end else begin
      done <= 1'b0;
      if (clr)
        out_valid <= 1'b0;
      else if (state == DRAIN && (!out_valid || out_ready)) begin
        if (last_out) begin
          out_valid <= 1'b0;
          done      <= 1'b1;
        end else begin
          out_valid <= 1'b1;
          out_idx   <= nxt_idx;
          out_data  <= mem[nxt_idx];
        end
      end
    end
  end

endmodule

// File: tb/tb_basemul_acc.sv
// Directed bench for basemul_acc with K=2: table of pair-0 corner values on a
// known background, plus clr and asynchronous-reset sequences.
module tb_basemul_acc;

  logic               clk = 1'b0;
  logic               set = 1'b0;
  logic               clr = 1'b0;
  logic               in_valid = 1'b0;
  logic               out_ready = 1'b0;
  logic signed [15:0] t0 = '0;
  logic signed [15:0] t1 = '0;
  logic               in_ready, out_valid, done;
  logic [11:0]        out_data;
  logic [7:0]         out_idx;

  always #5 clk = ~clk;

  basemul_acc #(.K(2), .Q(3329)) dut (
    .clk(clk), .set(set), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready), .t1(t1), .t0(t0),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_idx(out_idx), .done(done)
  );

  typedef struct {
    string name;
    int    p0t0, p0t1, p1t0, p1t1;
    int    e0, e1;
    bit    gaps, bp;
  } vec_t;

  vec_t tbl[7];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   a0[2][128];
  int   a1[2][128];
  int   expv[256];

  task automatic chk(input string nm, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Background: poly0 pairs (t1=2,t0=1), poly1 pairs (t1=4,t0=3) -> 4 even, 6 odd.
  task automatic load(input vec_t v);
    for (int i = 0; i < 128; i++) begin
      a0[0][i] = 1; a1[0][i] = 2;
      a0[1][i] = 3; a1[1][i] = 4;
      expv[2*i] = 4; expv[2*i+1] = 6;
    end
    a0[0][0] = v.p0t0; a1[0][0] = v.p0t1;
    a0[1][0] = v.p1t0; a1[1][0] = v.p1t1;
    expv[0] = v.e0; expv[1] = v.e1;
  endtask

  task automatic feed(input bit gaps, input int total);
    int idx = 0;
    int guard = 0;
    bit acc;
    while (idx < total && guard < 4000) begin
      @(negedge clk);
      in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      t0 = 16'(a0[idx / 128][idx % 128]);
      t1 = 16'(a1[idx / 128][idx % 128]);
      acc = in_valid && in_ready;
      @(posedge clk);
      if (acc) idx++;
      guard++;
    end
    chk("feed_accepts", idx, total);
  endtask

  task automatic drain(input bit bp, input bit chk_lat, input int stop_at);
    int n = 0;
    int negs = 0;
    int first = 0;
    bit prev_stall = 1'b0;
    int pd = 0;
    int pi = 0;
    while (n < stop_at && negs < 3000) begin
      @(negedge clk);
      in_valid = 1'b0;
      negs++;
      if (prev_stall) chk("stall_valid", int'(out_valid), 1);
      if (out_valid) begin
        if (first == 0) first = negs;
        if (prev_stall) begin
          chk("stall_data", int'(out_data), pd);
          chk("stall_idx", int'(out_idx), pi);
        end
        chk("drain_in_ready", int'(in_ready), 0);
        chk("drain_done", int'(done), 0);
      end
      out_ready = bp ? (((negs - 1) % 4 == 0) || ((negs - 1) % 4 == 3)) : 1'b1;
      if (out_valid && out_ready) begin
        chk("out_idx", int'(out_idx), n);
        chk("out_data", int'(out_data), expv[n]);
        n++;
      end
      prev_stall = out_valid && !out_ready;
      pd = int'(out_data);
      pi = int'(out_idx);
    end
    chk("beats", n, stop_at);
    if (chk_lat) chk("first_valid_latency", first, 3);
    if (stop_at == 256) begin
      @(negedge clk);
      chk("end_out_valid", int'(out_valid), 0);
      chk("end_done", int'(done), 1);
      chk("end_in_ready", int'(in_ready), 1);
      out_ready = 1'b0;
      @(negedge clk);
      chk("done_width", int'(done), 0);
    end
  endtask

  initial begin
    tbl[0] = '{"basic",    1,     2,     3,     4,     4,    6,    1'b0, 1'b0};
    tbl[1] = '{"wrap",     3000,  0,     3000,  0,     2671, 0,    1'b0, 1'b0};
    tbl[2] = '{"neg",      -5,    0,     3,     0,     3327, 0,    1'b0, 1'b0};
    tbl[3] = '{"bound",    -3328, 3328,  0,     0,     1,    3328, 1'b0, 1'b0};
    tbl[4] = '{"maxpos",   3328,  3328,  3328,  3328,  3327, 3327, 1'b0, 1'b1};
    tbl[5] = '{"maxneg",   -3328, -3328, -3328, -3328, 2,    2,    1'b1, 1'b0};
    tbl[6] = '{"gaps_bp",  1,     2,     3,     4,     4,    6,    1'b1, 1'b1};

    #12;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_out_idx", int'(out_idx), 0);
    @(negedge clk);
    set = 1'b1;
    #1 chk("post_rst_in_ready", int'(in_ready), 1);

    for (int v = 0; v < 7; v++) begin
      load(tbl[v]);
      feed(tbl[v].gaps, 256);
      drain(tbl[v].bp, 1'b1, 256);
    end

    // clr in the middle of accumulation, at pair 40 of poly 1 (that input is dropped)
    load(tbl[1]);
    feed(1'b0, 128 + 40);
    @(negedge clk);
    clr = 1'b1; in_valid = 1'b1;
    t0 = 16'(a0[1][40]); t1 = 16'(a1[1][40]);
    @(negedge clk);
    clr = 1'b0; in_valid = 1'b0;
    chk("clr_acc_in_ready", int'(in_ready), 1);
    chk("clr_acc_out_valid", int'(out_valid), 0);
    load(tbl[0]);
    feed(1'b0, 256);
    drain(1'b0, 1'b1, 256);

    // clr in the middle of drain
    load(tbl[3]);
    feed(1'b0, 256);
    drain(1'b0, 1'b0, 100);
    @(negedge clk);
    clr = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    clr = 1'b0;
    chk("clr_drain_out_valid", int'(out_valid), 0);
    chk("clr_drain_in_ready", int'(in_ready), 1);
    chk("clr_drain_done", int'(done), 0);
    repeat (3) begin
      @(negedge clk);
      chk("clr_drain_no_done", int'(done | out_valid), 0);
    end
    load(tbl[2]);
    feed(1'b0, 256);
    drain(1'b0, 1'b1, 256);

    // asynchronous reset between clock edges in the middle of drain
    load(tbl[4]);
    feed(1'b0, 256);
    drain(1'b0, 1'b0, 50);
    @(posedge clk);
    #2 set = 1'b0;
    #1;
    chk("async_out_valid", int'(out_valid), 0);
    chk("async_in_ready", int'(in_ready), 0);
    chk("async_out_idx", int'(out_idx), 0);
    out_ready = 1'b0;
    @(negedge clk);
    set = 1'b1;
    #1;
    chk("async_release_in_ready", int'(in_ready), 1);
    chk("async_release_out_valid", int'(out_valid), 0);
    load(tbl[1]);
    feed(1'b0, 256);
    drain(1'b0, 1'b1, 256);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
